serial_add_ctrl: RTL and testbench

//  Bit-serial add/subtract sequencer for the 8-bit ALU.

---
 rtl/alu_pkg.sv | 13 +
 rtl/bit_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 101 ++++++++++
 tb/tb_serial_add_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit ALU datapath blocks.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/bit_adder.sv
// One-bit full adder cell, reused by the bit-serial add/subtract sequencer.
module bit_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : bit_adder

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one bit_adder time-multiplexed over WIDTH cycles,
// LSB first, with a start/busy/done handshake and registered sum, carry and overflow.
module serial_add_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    serial_state_t    state;
    serial_state_t    state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic             sum_bit;
    logic             carry_bit;
    logic             last_bit;

    bit_adder u_bit_adder (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (sum_bit),
        .cout (carry_bit)
    );

    assign last_bit = (cnt == LAST_CNT);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, matching hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                        a_sh  <= a;
                        b_sh  <= (subtract == OP_SUB) ? ~b : b;
                        carry <= (subtract == OP_SUB);
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sh  <= {sum_bit, r_sh[WIDTH-1:1]};
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    carry <= carry_bit;
                    if (last_bit) begin
                        // carry here is the carry into the MSB; its xor with the MSB carry-out is signed overflow.
                        result    <= {sum_bit, r_sh[WIDTH-1:1]};
                        carry_out <= carry_bit;
                        overflow  <= carry ^ carry_bit;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       subtract;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       overflow;

    int tests_run = 0;
    int tests_failed = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .subtract  (subtract),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents an operation and holds start for exactly the accept edge.
    task automatic start_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_sub);
        a        = op_a;
        b        = op_b;
        subtract = op_sub;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        subtract = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen, bounded.
    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic op_sub, input logic [7:0] exp_r, input logic exp_c,
                          input logic exp_o);
        int edges;
        start_op(op_a, op_b, op_sub);
        check({tag, "_busy"}, busy, 1'b1);
        wait_done(tag, edges);
        check({tag, "_latency"}, edges, 8);
        check({tag, "_result"}, result, exp_r);
        check({tag, "_carry"}, carry_out, exp_c);
        check({tag, "_ovf"}, overflow, exp_o);
        @(posedge clk);
        #1;
        check({tag, "_done_1cyc"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_held"}, result, exp_r);
    endtask

    initial begin
        int  edges;
        logic seen_done;

        reset    = 1'b1;
        start    = 1'b0;
        subtract = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_carry", carry_out, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("add_3_5",    8'd3,  8'd5,  1'b0, 8'h08, 1'b0, 1'b0);
        run_op("add_ff_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub_5_3",    8'd5,  8'd3,  1'b1, 8'h02, 1'b1, 1'b0);
        run_op("sub_3_5",    8'd3,  8'd5,  1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_80_01",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Start while busy must be ignored.
        start_op(8'd1, 8'd1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a        = 8'hAA;
        b        = 8'h55;
        subtract = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        wait_done("ignore", edges);
        check("ignore_result", result, 8'h02);
        check("ignore_carry", carry_out, 1'b0);
        @(posedge clk);
        #1;
        check("ignore_idle", busy, 1'b0);
        @(posedge clk);
        #1;
        check("ignore_not_queued", busy, 1'b0);

        // Reset on the 4th RUN cycle aborts the operation with no done pulse.
        start_op(8'h40, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_pre", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 8'h00);
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 1'b0);

        run_op("add_2_2", 8'd2, 8'd2, 1'b0, 8'h04, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_serial_add_ctrl
